fp_loo_issue: RTL and testbench
===============================

Name: fp_loo_issue

Overview:
- Initiator/collector for the single-cycle-latency FP long-latency-op unit (ITOF, FTOI, TRUNC).
- Accepts one operation at a time from the FP reservation station over a valid/ready handshake.
- Drives the unit's ce/ir/rm/a/b inputs and waits for done.
- Captures the result with its tag and holds it in a 2-entry writeback buffer that drains to the CDB arbiter over valid/ready.

Parameters:
- FPWID, 52, operand/result width in bits.
- TAGW, 5, ROB tag width.
- TMO, 7, cycles to wait for done before forcing an error completion; only used with FP_LOO_TIMEOUT_EN; minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  operation offered.
- iss_ready  out  1  block can accept an operation this cycle.
- iss_ir  in  Instruction  instruction word (opcode, func5).
- iss_rm  in  3  rounding mode.
- iss_a  in  FPWID  operand a.
- iss_b  in  FPWID  operand b.
- iss_tag  in  TAGW  ROB tag.
- fu_ce  out  1  clock enable to the FP unit.
- fu_ir  out  Instruction  registered instruction to the unit.
- fu_rm  out  3  registered rounding mode.
- fu_a  out  FPWID  registered operand a.
- fu_b  out  FPWID  registered operand b.
- fu_done  in  1  unit result valid.
- fu_o  in  FPWID  unit result.
- wb_valid  out  1  writeback entry available.
- wb_ready  in  1  arbiter accepts the entry.
- wb_tag  out  TAGW  tag of head entry.
- wb_res  out  FPWID  result of head entry.
- wb_exc  out  1  head entry completed by timeout or unsupported op.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; buffer is empty.
  - Outputs: iss_ready=0 while reset is asserted, wb_valid=0, fu_ce=0, fu_ir/fu_a/fu_b/fu_rm=0, wb_tag/wb_res/wb_exc=0.
  - Reset mid-operation discards the in-flight op and all buffered entries. No partial writeback.
- iss_ready=1 only when state=IDLE and buffer count<2. The buffer slot is reserved at issue.
- Transfer occurs when iss_valid&iss_ready at a rising edge.
- FSM states:
  - IDLE, on transfer:
    - Register ir/rm/a/b/tag.
    - If the op is FLT1 with func5 ITOF/FTOI/TRUNC: go to BUSY and assert fu_ce.
    - Otherwise: go to REJ.
  - BUSY:
    - fu_ce=1; wait counter increments.
    - If fu_done=1: push {tag, fu_o, exc=0}, go to IDLE.
    - Nominal latency is transfer edge +2 cycles to push (unit delay1 is one cycle after fu_* are registered).
  - REJ: push {tag, res=0, exc=1} in one cycle, go to IDLE.
- fu_ce=0 in IDLE and REJ. fu_ir/fu_a/fu_b hold their last value.
- fu_done while in IDLE or REJ is spurious: it is ignored and does not push.
- Writeback buffer: 2-entry FIFO.
  - wb_* always show the head entry; wb_valid = count!=0.
  - Pop on wb_valid&wb_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers are 1 bit and wrap modulo 2.
  - Push never happens when full, because the slot is reserved at issue.
- Back-to-back throughput: one op per 3 cycles when wb_ready is held 1.

Optional Feature:
- Macro FP_LOO_TIMEOUT_EN.
- Defined: a counter clears on entry to BUSY. If fu_done has not arrived by count==TMO, push {tag, res=0, exc=1} and return to IDLE. A fu_done arriving on the timeout cycle takes priority (normal completion).
- Undefined: no counter; BUSY waits indefinitely for fu_done.

Decomposition:
- Shared package fp_loo_pkg:
  - typedef wb_entry_t {tag, res, exc}.
  - typedef enum state_t {IDLE, BUSY, REJ}.
  - Function is_loo_op(Instruction).
  - Localparam TMO_W = $clog2(TMO+1).
- One sub-module, fp_loo_wbq: the 2-entry writeback FIFO of wb_entry_t with push/pop/count.

Test Plan:
- Reset mid-op: issue ITOF a=52'h5, deassert rst_n at cycle 1 → wb_valid=0, iss_ready=0 during reset; after release, iss_ready=1 and no writeback appears.
- Basic ITOF: a=5, tag=3, wb_ready=1 → fu_ce=1 one cycle after transfer; fu_done with fu_o=X pushes; wb_valid=1, wb_tag=3, wb_res=X, wb_exc=0 two cycles after transfer.
- Unsupported op (FLT1 with func5 ≠ ITOF/FTOI/TRUNC, or non-FLT1 opcode), tag=7 → fu_ce stays 0; wb_tag=7, wb_res=0, wb_exc=1 one cycle after REJ.
- Backpressure: wb_ready=0, issue FTOI tag1 then TRUNC tag2 → both complete; iss_ready=0 once count=2; release wb_ready → tags pop in order 1,2, then iss_ready=1.
- Simultaneous push/pop: count=1, wb_ready=1, fu_done arrives → count stays 1; next head is the new tag.
- With FP_LOO_TIMEOUT_EN, TMO=7: hold fu_done=0 → exc entry pushed on the BUSY cycle where the counter reaches 7; fu_done on exactly that cycle → normal result, exc=0.

Source files
------------

// File: rtl/fp_loo_issue_pkg.sv
// Shared types and helpers for the FP long-latency-op issue block (package fp_loo_pkg).
// Instruction decode assumes opcode in ir[6:0] and func5 in ir[31:27].
package fp_loo_pkg;

  localparam int FPWID_D = 52;
  localparam int TAGW_D  = 5;
  localparam int TMO_D   = 7;
  localparam int TMO_W   = $clog2(TMO_D + 1);

  typedef logic [31:0] Instruction;

  localparam logic [6:0] OP_FLT1  = 7'h53;
  localparam logic [4:0] F5_ITOF  = 5'h1a;
  localparam logic [4:0] F5_FTOI  = 5'h18;
  localparam logic [4:0] F5_TRUNC = 5'h05;

  typedef enum logic [1:0] {IDLE, BUSY, REJ} state_t;

  typedef struct packed {
    logic [TAGW_D-1:0]  tag;
    logic [FPWID_D-1:0] res;
    logic               exc;
  } wb_entry_t;

  function automatic logic is_loo_op(Instruction ir);
    logic [4:0] f5;
    f5 = ir[31:27];
    return (ir[6:0] == OP_FLT1) && (f5 == F5_ITOF || f5 == F5_FTOI || f5 == F5_TRUNC);
  endfunction

endpackage

// File: rtl/fp_loo_issue_if.sv
// Issue, FP-unit and writeback signal bundle for fp_loo_issue.
// master = surrounding pipeline (RS, FP unit, CDB arbiter); slave = fp_loo_issue.
interface fp_loo_issue_if
  import fp_loo_pkg::*;
#(
  parameter int FPWID = FPWID_D,
  parameter int TAGW  = TAGW_D
) ();

  logic             iss_valid;
  logic             iss_ready;
  Instruction       iss_ir;
  logic [2:0]       iss_rm;
  logic [FPWID-1:0] iss_a;
  logic [FPWID-1:0] iss_b;
  logic [TAGW-1:0]  iss_tag;

  logic             fu_ce;
  Instruction       fu_ir;
  logic [2:0]       fu_rm;
  logic [FPWID-1:0] fu_a;
  logic [FPWID-1:0] fu_b;
  logic             fu_done;
  logic [FPWID-1:0] fu_o;

  logic             wb_valid;
  logic             wb_ready;
  logic [TAGW-1:0]  wb_tag;
  logic [FPWID-1:0] wb_res;
  logic             wb_exc;

  modport master (
    output iss_valid, iss_ir, iss_rm, iss_a, iss_b, iss_tag, fu_done, fu_o, wb_ready,
    input  iss_ready, fu_ce, fu_ir, fu_rm, fu_a, fu_b, wb_valid, wb_tag, wb_res, wb_exc
  );

  modport slave (
    input  iss_valid, iss_ir, iss_rm, iss_a, iss_b, iss_tag, fu_done, fu_o, wb_ready,
    output iss_ready, fu_ce, fu_ir, fu_rm, fu_a, fu_b, wb_valid, wb_tag, wb_res, wb_exc
  );

endinterface

// File: rtl/fp_loo_issue_wbq.sv
// fp_loo_wbq: 2-entry writeback FIFO; head is always visible, 1-bit pointers wrap modulo 2.
// Callers guarantee no push when full and no pop when empty.
module fp_loo_wbq #(
  parameter type T = fp_loo_pkg::wb_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  T           push_data,
  input  logic       pop,
  output T           head,
  output logic [1:0] count
);

  T     mem [2];
  logic wr_ptr;
  logic rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fp_loo_issue.sv
// Issue/collect stage for the FP long-latency-op unit (ITOF/FTOI/TRUNC) with a 2-entry writeback queue.
// Optional macro FP_LOO_TIMEOUT_EN: complete with exc=1 after TMO BUSY cycles without fu_done.
module fp_loo_issue
  import fp_loo_pkg::*;
#(
  parameter int FPWID = FPWID_D,
  parameter int TAGW  = TAGW_D,
  parameter int TMO   = TMO_D
) (
  input logic           clk,
  input logic           rst_n,
  fp_loo_issue_if.slave bus
);

  typedef struct packed {
    logic [TAGW-1:0]  tag;
    logic [FPWID-1:0] res;
    logic             exc;
  } entry_t;

  state_t          state;
  logic [TAGW-1:0] tag_q;
  logic            tmo_hit;
  logic            push;
  logic            pop;
  entry_t          push_data;
  entry_t          head;
  logic [1:0]      count;

`ifdef FP_LOO_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] wait_cnt;
  assign tmo_hit = (wait_cnt == CW'(TMO));
`else
  assign tmo_hit = 1'b0;
`endif

  // Only one op is ever in flight, so IDLE with a free slot means the slot is reserved at issue.
  assign bus.iss_ready = rst_n && (state == IDLE) && (count != 2'd2);
  assign pop           = bus.wb_valid && bus.wb_ready;

  always_comb begin
    push           = 1'b0;
    push_data.tag  = tag_q;
    push_data.res  = '0;
    push_data.exc  = 1'b0;
    case (state)
      BUSY: begin
        if (bus.fu_done) begin
          push          = 1'b1;
          push_data.res = bus.fu_o;
        end else if (tmo_hit) begin
          push          = 1'b1;
          push_data.exc = 1'b1;
        end
      end
      REJ: begin
        push          = 1'b1;
        push_data.exc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tag_q      <= '0;
      bus.fu_ce  <= 1'b0;
      bus.fu_ir  <= '0;
      bus.fu_rm  <= '0;
      bus.fu_a   <= '0;
      bus.fu_b   <= '0;
`ifdef FP_LOO_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.iss_valid && bus.iss_ready) begin
            tag_q     <= bus.iss_tag;
            bus.fu_ir <= bus.iss_ir;
            bus.fu_rm <= bus.iss_rm;
            bus.fu_a  <= bus.iss_a;
            bus.fu_b  <= bus.iss_b;
            if (is_loo_op(bus.iss_ir)) begin
              state     <= BUSY;
              bus.fu_ce <= 1'b1;
`ifdef FP_LOO_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end else begin
              state <= REJ;
            end
          end
        end
        BUSY: begin
          if (push) begin
            state     <= IDLE;
            bus.fu_ce <= 1'b0;
          end
`ifdef FP_LOO_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        REJ:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fp_loo_wbq #(.T(entry_t)) u_wbq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.wb_valid = (count != 2'd0);
  assign bus.wb_tag   = head.tag;
  assign bus.wb_res   = head.res;
  assign bus.wb_exc   = head.exc;

endmodule

// File: tb/tb_fp_loo_issue.sv
// Bench for fp_loo_issue: directed cases plus random traffic against an in-order transaction model.
// Timeout cases are compiled in when FP_LOO_TIMEOUT_EN is defined.
module tb_fp_loo_issue;
  import fp_loo_pkg::*;

  localparam int FPWID = 52;
  localparam int TAGW  = 5;
  localparam int TMO   = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_loo_issue_if #(.FPWID(FPWID), .TAGW(TAGW)) bus ();

  fp_loo_issue #(.FPWID(FPWID), .TAGW(TAGW), .TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic [TAGW-1:0]  tag;
    logic [FPWID-1:0] res;
    logic             exc;
  } exp_t;

  exp_t             exp_q[$];
  bit               stall      = 1'b0;
  bit               force_done = 1'b0;
  bit               exp_forced = 1'b0;
  logic [FPWID-1:0] manual_res = '0;

  function automatic logic [FPWID-1:0] unit_fn(logic [FPWID-1:0] a, logic [FPWID-1:0] b, logic [2:0] rm);
    return a ^ {b[FPWID-2:0], 1'b0} ^ FPWID'(rm);
  endfunction

  function automatic bit supported(Instruction ir);
    logic [4:0] f5;
    f5 = ir[31:27];
    return (ir[6:0] == 7'h53) && (f5 == 5'h1a || f5 == 5'h18 || f5 == 5'h05);
  endfunction

  function automatic Instruction mk_ir(logic [6:0] opc, logic [4:0] f5);
    return {f5, 20'h0, opc};
  endfunction

  // Behavioural FP unit: done and result one cycle after it sees ce.
  initial begin : unit_model
    logic             ce_s;
    logic [FPWID-1:0] a_s, b_s;
    logic [2:0]       rm_s;
    bus.fu_done = 1'b0;
    bus.fu_o    = '0;
    forever begin
      @(negedge clk);
      ce_s = bus.fu_ce; a_s = bus.fu_a; b_s = bus.fu_b; rm_s = bus.fu_rm;
      @(posedge clk);
      #2;
      if (force_done) begin
        bus.fu_done = 1'b1;
        bus.fu_o    = manual_res;
      end else begin
        bus.fu_done = ce_s && !stall;
        bus.fu_o    = ce_s ? unit_fn(a_s, b_s, rm_s) : '0;
      end
    end
  end

  // Transaction model: every accepted op yields exactly one writeback, in issue order.
  initial begin : monitor
    bit               pend;
    bit               pend_sup;
    logic [FPWID-1:0] pend_a;
    exp_t             e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("fu_ce_after_issue", bus.fu_ce, pend_sup);
          if (pend_sup) chk("fu_a_after_issue", bus.fu_a, pend_a);
          pend = 1'b0;
        end
        if (bus.iss_ready) chk("ready_with_room", exp_q.size() < 2, 1'b1);
        if (bus.wb_valid && bus.wb_ready) begin
          if (exp_q.size() == 0) begin
            chk("wb_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("wb_tag", bus.wb_tag, e.tag);
            chk("wb_res", bus.wb_res, e.res);
            chk("wb_exc", bus.wb_exc, e.exc);
          end
        end
        if (bus.iss_valid && bus.iss_ready) begin
          e.tag = bus.iss_tag;
          if (!supported(bus.iss_ir)) begin e.res = '0; e.exc = 1'b1; end
          else if (exp_forced)        begin e.res = manual_res; e.exc = 1'b0; end
          else if (stall)             begin e.res = '0; e.exc = 1'b1; end
          else begin e.res = unit_fn(bus.iss_a, bus.iss_b, bus.iss_rm); e.exc = 1'b0; end
          exp_q.push_back(e);
          pend     = 1'b1;
          pend_sup = supported(bus.iss_ir);
          pend_a   = bus.iss_a;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns 1 time unit after the transfer edge.
  task automatic issue(input Instruction ir, input logic [2:0] rm, input logic [FPWID-1:0] a,
                       input logic [FPWID-1:0] b, input logic [TAGW-1:0] tag);
    int n;
    n = 0;
    bus.iss_ir = ir; bus.iss_rm = rm; bus.iss_a = a; bus.iss_b = b; bus.iss_tag = tag;
    bus.iss_valid = 1'b1;
    @(negedge clk);
    while (!bus.iss_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("issue_accepted", bus.iss_ready, 1'b1);
    tick();
    bus.iss_valid = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit took;
    int n;
    bus.iss_valid = 1'b0; bus.iss_ir = '0; bus.iss_rm = '0;
    bus.iss_a = '0; bus.iss_b = '0; bus.iss_tag = '0; bus.wb_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_iss_ready", bus.iss_ready, 1'b0);
    chk("rst_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_fu_ce", bus.fu_ce, 1'b0);
    chk("rst_fu_a", bus.fu_a, '0);
    chk("rst_wb_tag", bus.wb_tag, '0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.iss_ready, 1'b1);

    // Basic ITOF
    tick(); bus.wb_ready = 1'b1;
    issue(mk_ir(OP_FLT1, F5_ITOF), 3'd0, 52'h5, 52'h0, 5'd3);
    @(negedge clk);
    chk("itof_fu_ce", bus.fu_ce, 1'b1);
    chk("itof_wbv_c1", bus.wb_valid, 1'b0);
    @(negedge clk);
    chk("itof_wbv_c2", bus.wb_valid, 1'b0);
    @(negedge clk);
    chk("itof_wbv", bus.wb_valid, 1'b1);
    chk("itof_tag", bus.wb_tag, 5'd3);
    chk("itof_res", bus.wb_res, 52'h5);
    chk("itof_exc", bus.wb_exc, 1'b0);

    // Unsupported func5 and non-FLT1 opcode
    tick();
    issue(mk_ir(OP_FLT1, 5'h03), 3'd1, 52'habc, 52'h1, 5'd7);
    @(negedge clk);
    chk("rej_fu_ce", bus.fu_ce, 1'b0);
    chk("rej_wbv_c1", bus.wb_valid, 1'b0);
    @(negedge clk);
    chk("rej_wbv", bus.wb_valid, 1'b1);
    chk("rej_tag", bus.wb_tag, 5'd7);
    chk("rej_res", bus.wb_res, '0);
    chk("rej_exc", bus.wb_exc, 1'b1);
    tick();
    issue(mk_ir(7'h13, F5_ITOF), 3'd2, 52'h77, 52'h2, 5'd8);
    @(negedge clk);
    chk("rej2_fu_ce", bus.fu_ce, 1'b0);
    @(negedge clk);
    chk("rej2_tag", bus.wb_tag, 5'd8);
    chk("rej2_exc", bus.wb_exc, 1'b1);

    // Backpressure: fill both slots, then drain in order
    tick(); bus.wb_ready = 1'b0;
    issue(mk_ir(OP_FLT1, F5_FTOI), 3'd3, 52'h100, 52'h7, 5'd1);
    issue(mk_ir(OP_FLT1, F5_TRUNC), 3'd4, 52'h200, 52'h9, 5'd2);
    repeat (3) @(negedge clk);
    chk("bp_full_ready", bus.iss_ready, 1'b0);
    chk("bp_wbv", bus.wb_valid, 1'b1);
    chk("bp_head1", bus.wb_tag, 5'd1);
    tick(); bus.wb_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_head2", bus.wb_tag, 5'd2);
    chk("bp_ready_one_left", bus.iss_ready, 1'b1);
    @(negedge clk);
    chk("bp_empty", bus.wb_valid, 1'b0);
    chk("bp_ready_end", bus.iss_ready, 1'b1);

    // Simultaneous push and pop with one entry held
    tick(); bus.wb_ready = 1'b0;
    issue(mk_ir(OP_FLT1, F5_ITOF), 3'd0, 52'h11, 52'h0, 5'd4);
    repeat (3) @(negedge clk);
    tick();
    issue(mk_ir(OP_FLT1, F5_FTOI), 3'd5, 52'h22, 52'h3, 5'd9);
    @(negedge clk);
    chk("sp_head_old", bus.wb_tag, 5'd4);
    tick(); bus.wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("sp_wbv", bus.wb_valid, 1'b1);
    chk("sp_head_new", bus.wb_tag, 5'd9);
    @(negedge clk);
    chk("sp_single_entry", bus.wb_valid, 1'b0);

    // Reset mid-operation
    tick();
    issue(mk_ir(OP_FLT1, F5_ITOF), 3'd0, 52'h5, 52'h0, 5'd10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmid_wbv", bus.wb_valid, 1'b0);
    chk("rmid_ready", bus.iss_ready, 1'b0);
    chk("rmid_fu_ce", bus.fu_ce, 1'b0);
    tick(); tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("rmid_ready_after", bus.iss_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rmid_no_wb", bus.wb_valid, 1'b0);
    end

`ifdef FP_LOO_TIMEOUT_EN
    // Timeout with no done, then done landing exactly on the timeout cycle
    tick(); stall = 1'b1;
    issue(mk_ir(OP_FLT1, F5_ITOF), 3'd0, 52'h33, 52'h0, 5'd12);
    repeat (TMO + 1) @(negedge clk);
    chk("tmo_early", bus.wb_valid, 1'b0);
    @(negedge clk);
    chk("tmo_wbv", bus.wb_valid, 1'b1);
    chk("tmo_tag", bus.wb_tag, 5'd12);
    chk("tmo_exc", bus.wb_exc, 1'b1);
    chk("tmo_res", bus.wb_res, '0);
    tick(); exp_forced = 1'b1; manual_res = 52'h1234;
    issue(mk_ir(OP_FLT1, F5_FTOI), 3'd0, 52'h44, 52'h0, 5'd13);
    repeat (TMO) tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    @(negedge clk);
    chk("tmo_prio_wbv", bus.wb_valid, 1'b1);
    chk("tmo_prio_exc", bus.wb_exc, 1'b0);
    chk("tmo_prio_res", bus.wb_res, 52'h1234);
    tick(); stall = 1'b0; exp_forced = 1'b0;
`endif

    // Random traffic with random backpressure
    tick();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      took = bus.iss_valid && bus.iss_ready;
      tick();
      if (took) bus.iss_valid = 1'b0;
      if (!bus.iss_valid && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0:       bus.iss_ir = mk_ir(OP_FLT1, F5_ITOF);
          1:       bus.iss_ir = mk_ir(OP_FLT1, F5_FTOI);
          2:       bus.iss_ir = mk_ir(OP_FLT1, F5_TRUNC);
          3:       bus.iss_ir = mk_ir(OP_FLT1, 5'($urandom));
          4:       bus.iss_ir = mk_ir(7'($urandom), 5'($urandom));
          default: bus.iss_ir = mk_ir(OP_FLT1, F5_ITOF);
        endcase
        bus.iss_ir[26:7] = 20'($urandom);
        bus.iss_rm  = 3'($urandom);
        bus.iss_a   = FPWID'({$urandom(), $urandom()});
        bus.iss_b   = FPWID'({$urandom(), $urandom()});
        bus.iss_tag = TAGW'($urandom);
        bus.iss_valid = 1'b1;
      end
      bus.wb_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain
    bus.wb_ready = 1'b1;
    n = 0;
    while (bus.iss_valid && n < 200) begin
      @(negedge clk);
      took = bus.iss_valid && bus.iss_ready;
      tick();
      if (took) bus.iss_valid = 1'b0;
      n++;
    end
    repeat (20) tick();
    chk("drain_outstanding", exp_q.size(), 0);
    chk("drain_wbv", bus.wb_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
